n2r_chunk_dispatch: RTL
=======================

# n2r_chunk_dispatch

Elastic buffer and sequencer between the input normal-to-ready buffer and the multi-core MAC array. It captures the block-ordered chunk words the n2r stage emits at its own pace, which cannot be back-pressured. It then replays them to the MAC cores under a valid/ready handshake, tagging slice boundaries and end of matrix. It also checks slice alignment and flags overflow, so the MAC array may stall without corrupting the stream.

## Interface
- WIDTH, 16: bits per fixed-point element.
- FRAC_WIDTH, 8: fractional bits; pass-through only, no arithmetic.
- BLOCK_SIZE, 2: systolic block edge.
- CHUNK_SIZE, 4: elements per core per chunk word.
- ROW, 64: matrix rows.
- COL, 256: matrix columns.
- NUM_CORES, 8: MAC cores fed in parallel.
- FIFO_DEPTH, 16: chunk words buffered; power of two, ≥ 2.
- Derived values:
  - W = WIDTH*CHUNK_SIZE*NUM_CORES.
  - CPS (chunks per slice) = COL/BLOCK_SIZE.
  - NSL (slices) = ROW/(NUM_CORES*BLOCK_SIZE); must be an integer.

- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  start; sampled in IDLE only.
- in_valid  in  1  chunk word present (driven by n2r output_ready).
- in_data  in  W  chunk word; core k occupies bits [(k+1)*WIDTH*CHUNK_SIZE-1 -: WIDTH*CHUNK_SIZE].
- in_last  in  1  final chunk of a slice (driven by n2r slice_done).
- out_ready  in  1  MAC array accepts the current word.
- out_valid  out  1  head word valid.
- out_data  out  W  head word, bit-identical to the captured in_data.
- out_first  out  1  head word is chunk 0 of its slice.
- out_last  out  1  head word is chunk CPS-1 of its slice.
- out_done  out  1  one-cycle pulse after the final chunk of slice NSL-1 is accepted.
- fill_count  out  $clog2(FIFO_DEPTH)+1  words currently stored.
- err_overflow  out  1  sticky; a word was dropped because the FIFO was full.
- err_align  out  1  sticky; in_last disagreed with the input chunk counter.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN when en=1.
  - RUN → DONE on the cycle the last chunk of the last slice is accepted (out_valid & out_ready & out_last & slice_cnt==NSL-1).
  - DONE → IDLE unconditionally on the next cycle.
- IDLE:
  - in_valid ignored; no write, no error flag.
  - out_valid=0.
  - All counters and the FIFO are cleared.
- RUN write:
  - Accepted if in_valid & (fill_count<FIFO_DEPTH or a pop occurs in the same cycle).
  - in_valid at full without a pop drops the word and sets err_overflow.
- RUN read:
  - out_valid = (fill_count≠0).
  - A pop occurs on out_valid & out_ready.
  - With out_valid=1 and out_ready=0, out_data and tags hold stable.
- Input chunk counter ic (0..CPS-1):
  - Advances on each accepted write and wraps at CPS-1.
  - err_align is set if in_last=1 with ic≠CPS-1, or in_last=0 with ic=CPS-1.
  - Data is stored regardless of err_align.
- Output counters:
  - oc (0..CPS-1) advances on each pop.
  - At wrap, slice_cnt (0..NSL-1) increments.
  - out_first = out_valid & oc==0.
  - out_last = out_valid & oc==CPS-1.
- DONE:
  - out_done=1 and out_valid=0.
  - Writes are ignored.
  - FIFO and counters clear on entry to IDLE.
- Errors: err_* clear only on rst; they survive DONE→IDLE.
- Words left in the FIFO after the final pop are discarded by the clear, and err_overflow is not set for them.

## Timing
- Reset values: out_valid, out_first, out_last, out_done, err_overflow and err_align are 0. fill_count=0. out_data=0. State is IDLE.
- rst mid-operation: the next cycle is IDLE with everything cleared, including sticky flags.
- Latency:
  - A word written in cycle t is visible with out_valid=1 in cycle t+1 if the FIFO was empty.
  - Sustained throughput is 1 word/cycle when out_ready=1.
- fill_count updates on the cycle after the write/pop; a simultaneous write and pop leaves it unchanged.
- out_done is asserted exactly one cycle, the cycle following the final pop.
- out_data must come from a registered FIFO head (first-word fall-through). There must be no combinational path from in_* to out_*.

## Test plan
Bench config for all scenarios: WIDTH=16, CHUNK_SIZE=4, NUM_CORES=2, BLOCK_SIZE=2, ROW=8, COL=8, FIFO_DEPTH=4. This gives W=128, CPS=4, NSL=2.

- Streaming pass-through: out_ready=1, en pulse, then 8 words 0x1..0x8 with in_last on words 4 and 8. Required:
  - out_data 0x1..0x8, each one cycle after its write.
  - out_first on 0x1 and 0x5; out_last on 0x4 and 0x8.
  - out_done one cycle after 0x8 is accepted, then IDLE.
  - Both error flags stay 0.
- Backpressure: out_ready=0 while 4 words are written, then out_ready=1. Required:
  - fill_count reaches 4 and out_data holds 0x1 throughout the stall.
  - The drain yields 0x1..0x4 in order.
  - No err_overflow.
- Overflow: out_ready=0 and 5 words written. Required:
  - The 5th word is dropped and err_overflow=1.
  - Draining yields only 0x1..0x4.
  - err_overflow persists after out_done and clears only on rst.
- Full with simultaneous pop: fill_count=4, out_ready=1 and in_valid=1 in the same cycle. Required: the write is accepted, fill_count stays 4, no err_overflow.
- Alignment error: in_last asserted on word 3. Required: err_align=1 from the next cycle; out_last still asserts on word 4.
- Mid-run reset: rst asserted after 3 words. Required:
  - The next cycle has out_valid=0, fill_count=0, all flags 0, state IDLE.
  - Writes are ignored until en is asserted again.

Source files
------------

// File: rtl/n2r_chunk_dispatch_if.sv
// n2r_chunk_dispatch_if
// Chunk-word stream bundle. On one side is the n2r normal-to-ready buffer,
// which writes chunk words. On the other side is the MAC array, which
// consumes them.
//   in_valid  : chunk word present (n2r output_ready)
//   in_data   : W-bit chunk word, core k in slice [(k+1)*WIDTH*CHUNK_SIZE-1 -: WIDTH*CHUNK_SIZE]
//   in_last   : final chunk of a slice (n2r slice_done)
//   out_ready : MAC array accepts the head word
//   out_valid : head word valid
//   out_data  : head word
//   out_first : head word is chunk 0 of its slice
//   out_last  : head word is the final chunk of its slice
// The slave modport is the dispatcher's view.
// The master modport is the view of whoever drives the stream and back-pressure.
interface n2r_chunk_dispatch_if #(
  parameter int W = 128
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_first;
  logic         out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  out_valid, out_data, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output out_valid, out_data, out_first, out_last
  );
endinterface

// File: rtl/n2r_chunk_dispatch.sv
// n2r_chunk_dispatch
// Elastic buffer and sequencer between the n2r buffer and the MAC array.
// Chunk words arrive at the n2r pace and cannot be stalled. They are kept in
// a small FIFO and replayed under valid/ready, tagged with the first and last
// chunk of each slice. The frame ends after the last chunk of the last slice
// is accepted.
// Ports:
//   clk, rst     : single clock; synchronous active-high reset
//   en           : start request, honoured only in IDLE
//   bus          : chunk stream (slave modport of n2r_chunk_dispatch_if)
//   out_done     : one-cycle pulse after the final chunk of the frame is accepted
//   fill_count   : words currently stored
//   err_overflow : sticky; a word arrived while full with no pop and was dropped
//   err_align    : sticky; in_last disagreed with the input chunk position
module n2r_chunk_dispatch #(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int BLOCK_SIZE = 2,
  parameter int CHUNK_SIZE = 4,
  parameter int ROW        = 64,
  parameter int COL        = 256,
  parameter int NUM_CORES  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  n2r_chunk_dispatch_if.slave          bus,
  output logic                         out_done,
  output logic [$clog2(FIFO_DEPTH):0]  fill_count,
  output logic                         err_overflow,
  output logic                         err_align
);

  localparam int W   = WIDTH * CHUNK_SIZE * NUM_CORES;
  localparam int CPS = COL / BLOCK_SIZE;
  localparam int NSL = ROW / (NUM_CORES * BLOCK_SIZE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (CPS > 1) ? $clog2(CPS) : 1;
  localparam int SW  = (NSL > 1) ? $clog2(NSL) : 1;

  localparam logic [CW-1:0] LAST_CHUNK = CW'(CPS - 1);
  localparam logic [SW-1:0] LAST_SLICE = SW'(NSL - 1);
  localparam logic [AW:0]   FULL       = (AW + 1)'(FIFO_DEPTH);

  // Configuration sanity, caught at elaboration time.
  // The pointers rely on natural wrap, so the depth must be a power of two.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("n2r_chunk_dispatch: FIFO_DEPTH must be a power of two >= 2");
  end
  if (ROW % (NUM_CORES * BLOCK_SIZE) != 0) begin : g_bad_slices
    $error("n2r_chunk_dispatch: ROW must be a multiple of NUM_CORES*BLOCK_SIZE");
  end
  if (FRAC_WIDTH > WIDTH) begin : g_bad_frac
    $error("n2r_chunk_dispatch: FRAC_WIDTH exceeds WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] ic;
  logic [CW-1:0] oc;
  logic [SW-1:0] slice_cnt;

  logic head_valid;
  logic pop;
  logic push;
  logic ic_at_end;

  // Handshake decode. Everything here depends only on registered state plus
  // out_ready and in_valid, so in_* never reaches out_* combinationally.
  // A write while full is still taken when the head leaves in the same cycle.
  assign head_valid = (state == RUN) && (count != '0);
  assign pop        = head_valid && bus.out_ready;
  assign push       = (state == RUN) && bus.in_valid && ((count != FULL) || pop);
  assign ic_at_end  = (ic == LAST_CHUNK);

  // The head word is read straight out of the storage registers (first-word
  // fall-through). It is forced to zero whenever nothing valid is presented.
  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_valid ? mem[rd_ptr] : '0;
  assign bus.out_first = head_valid && (oc == '0);
  assign bus.out_last  = head_valid && (oc == LAST_CHUNK);
  assign out_done      = (state == DONE);
  assign fill_count    = count;

  // Data storage only. The reset and clear logic acts on the pointers and the
  // count, so stale words here are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Sequencer. It owns the state, the FIFO pointers and count, the chunk and
  // slice counters, and the sticky error flags. IDLE and DONE both hold the
  // buffer empty. Any words left over when the frame ends are simply
  // forgotten, and they do not raise err_overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ic           <= '0;
      oc           <= '0;
      slice_cnt    <= '0;
      err_overflow <= 1'b0;
      err_align    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wr_ptr    <= '0;
          rd_ptr    <= '0;
          count     <= '0;
          ic        <= '0;
          oc        <= '0;
          slice_cnt <= '0;
          if (en) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            ic     <= ic_at_end ? '0 : ic + 1'b1;
            // The word is kept even when its slice tag looks wrong.
            if (bus.in_last != ic_at_end) begin
              err_align <= 1'b1;
            end
          end else if (bus.in_valid) begin
            err_overflow <= 1'b1;
          end

          if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (oc == LAST_CHUNK) begin
              oc        <= '0;
              slice_cnt <= (slice_cnt == LAST_SLICE) ? '0 : slice_cnt + 1'b1;
              if (slice_cnt == LAST_SLICE) begin
                state <= DONE;
              end
            end else begin
              oc <= oc + 1'b1;
            end
          end

          if (push && !pop) begin
            count <= count + 1'b1;
          end else if (pop && !push) begin
            count <= count - 1'b1;
          end
        end

        DONE: begin
          wr_ptr    <= '0;
          rd_ptr    <= '0;
          count     <= '0;
          ic        <= '0;
          oc        <= '0;
          slice_cnt <= '0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
